// File: rtl/button_conditioner.sv
// Push-button conditioner: synchroniser, debounce FSM, press/release/auto-repeat pulses
// and a clean debounced level, all registered on clk.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | button released and accepted as released
// DB_PRESS | btn_s high, counting stable cycles before accepting press
// HELD     | press accepted, timing the delay to the first repeat
// REPEAT   | auto-repeat active, pulsing every REPEAT_RATE_CYCLES
// DB_REL   | btn_s low, counting stable cycles before accepting release
module button_conditioner #(
  parameter int SYNC_STAGES         = 2,
  parameter int DEBOUNCE_CYCLES     = 50000,
  parameter int REPEAT_DELAY_CYCLES = 2500000,
  parameter int REPEAT_RATE_CYCLES  = 1000000,
  parameter int CNT_W               = 22
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  input  logic repeat_en,
  output logic button_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse,
  output logic step_pulse,
  output logic long_press
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DB_PRESS = 3'd1,
    HELD     = 3'd2,
    REPEAT   = 3'd3,
    DB_REL   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_MAX = CNT_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] RR_MAX = CNT_W'(REPEAT_RATE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;
  logic                   repeat_q, repeat_d;
  logic                   long_q, long_d;
  logic                   btn_s;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], button};
  assign btn_s  = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q    <= '0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
      long_q    <= long_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (btn_s) state_d = DB_PRESS;
      end
      DB_PRESS: begin
        if (!btn_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_MAX) begin
          state_d = HELD;
          cnt_d   = '0;
          press_d = 1'b1;
          level_d = 1'b1;
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_d = DB_REL;
          cnt_d   = '0;
        end else if (cnt_q == RD_MAX) begin
          // With repeat disabled the delay timer parks at its terminal count.
          if (repeat_en) begin
            state_d  = REPEAT;
            cnt_d    = '0;
            repeat_d = 1'b1;
          end else begin
            cnt_d = cnt_q;
          end
        end
      end
      REPEAT: begin
        if (!btn_s) begin
          state_d = DB_REL;
          cnt_d   = '0;
        end else if (!repeat_en) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == RR_MAX) begin
          cnt_d    = '0;
          repeat_d = 1'b1;
        end
      end
      DB_REL: begin
        if (btn_s) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == DB_MAX) begin
          state_d   = IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
          level_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
    long_d = (state_d == REPEAT);
  end

  assign button_level  = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign repeat_pulse  = repeat_q;
  assign step_pulse    = press_q | repeat_q;
  assign long_press    = long_q;

endmodule
